// File: rtl/btb_update_queue.sv
// Filters EX branch resolutions down to BTB-write-worthy updates, queues them and
// drains one per cycle into the BTB write port. Optional coalescing: BTB_UPD_COALESCE_EN.
module btb_update_queue #(
  parameter int ADDR_WIDTH     = 26,
  parameter int DEPTH          = 4,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_res_valid,
  input  logic [ADDR_WIDTH-1:0]     i_res_pc,
  input  logic [ADDR_WIDTH-1:0]     i_res_target,
  input  logic                      i_res_taken,
  input  logic                      i_res_btb_hit,
  input  logic [ADDR_WIDTH-1:0]     i_res_pred_target,
  output logic                      o_res_ready,
  input  logic                      i_btb_wready,
  output logic                      o_btb_we,
  output logic [ADDR_WIDTH-1:0]     o_btb_wpc,
  output logic [ADDR_WIDTH-1:0]     o_btb_wtarget,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic [DROP_CNT_WIDTH-1:0] o_drop_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] pc_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] tgt_mem [DEPTH];

  logic [PW-1:0]             rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic qual, pop, push, drop, full, coal;

  assign qual = i_res_valid & i_res_taken &
                (~i_res_btb_hit | (i_res_pred_target != i_res_target));
  assign full        = (cnt_q == CW'(DEPTH));
  assign o_btb_we    = (cnt_q != '0);
  assign pop         = o_btb_we & i_btb_wready;
  assign o_res_ready = ~full | pop;

`ifdef BTB_UPD_COALESCE_EN
  logic [DEPTH-1:0] hit_vec;
  logic [PW-1:0]    co_slot;
  logic             co_any, co_head;

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    logic [PW-1:0] age;
    assign age        = PW'(g) - rd_q;
    assign hit_vec[g] = ({1'b0, age} < cnt_q) && (pc_mem[g] == i_res_pc);
  end

  // Walk head->tail so the last hit seen is the youngest.
  always_comb begin
    co_any  = 1'b0;
    co_head = 1'b0;
    co_slot = rd_q;
    for (int a = 0; a < DEPTH; a++) begin
      if (hit_vec[rd_q + PW'(a)]) begin
        co_any  = 1'b1;
        co_slot = rd_q + PW'(a);
        co_head = (a == 0);
      end
    end
  end

  // A head that leaves this edge can't absorb the update; it gets a fresh entry.
  assign coal = qual & co_any & ~(co_head & pop);
`else
  assign coal = 1'b0;
`endif

  assign push = qual & o_res_ready & ~coal;
  assign drop = qual & ~o_res_ready & ~coal;

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (pop)  rd_d = rd_q + 1'b1;
    if (push) wr_d = wr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (drop && !(&drop_q)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  // Payload storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]  <= i_res_pc;
      tgt_mem[wr_q] <= i_res_target;
    end
`ifdef BTB_UPD_COALESCE_EN
    if (coal) tgt_mem[co_slot] <= i_res_target;
`endif
  end

  assign o_btb_wpc     = pc_mem[rd_q];
  assign o_btb_wtarget = tgt_mem[rd_q];
  assign o_count       = cnt_q;
  assign o_drop_count  = drop_q;
endmodule
